// File: rtl/instruction_memory.sv
// Byte-addressed instruction store with a fixed multi-cycle fetch latency.
// Ports: CLK/RESET, READ/ADDRESS fetch, INSTRUCTION/BUSYWAIT/ERROR, LOAD_* byte writes.
module instruction_memory #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 32,
  parameter int LATENCY = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               READ,
  input  logic [ADDR_W-1:0]  ADDRESS,
  output logic [INSTR_W-1:0] INSTRUCTION,
  output logic               BUSYWAIT,
  output logic               ERROR,
  input  logic               LOAD_EN,
  input  logic [ADDR_W-1:0]  LOAD_ADDR,
  input  logic [7:0]         LOAD_DATA
);

  localparam int NB    = INSTR_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [INSTR_W-1:0]   instr_q;
  logic                 err_q;
  logic                 err_d;
  logic [7:0]           mem_q [DEPTH];
  logic [INSTR_W-1:0]   rd_word;
  logic                 aligned;
  logic                 is_idle;
  logic                 start;
  logic                 bad_rd;
  logic                 bad_ld;

  assign aligned = (ADDRESS & ADDR_W'(NB - 1)) == '0;
  assign is_idle = state_q == IDLE;
  assign start   = is_idle & READ & aligned;
  assign bad_rd  = is_idle & READ & ~aligned;
  assign bad_ld  = ~is_idle & LOAD_EN;

  assign BUSYWAIT    = start | (state_q == WAIT);
  assign INSTRUCTION = instr_q;
  assign ERROR       = err_q;

  always_comb begin
    err_d = 1'b0;
    unique case (1'b1)
      bad_rd:  err_d = 1'b1;
      bad_ld:  err_d = 1'b1;
      default: err_d = 1'b0;
    endcase
  end

  // Little-endian assembly from the address captured at request time.
  always_comb begin
    rd_word = '0;
    for (int b = 0; b < NB; b++) begin
      rd_word[8*b +: 8] = mem_q[addr_q + ADDR_W'(b)];
    end
  end

  // Storage is deliberately outside the reset domain so code survives reset.
  always_ff @(posedge CLK) begin
    if (RESET && is_idle && LOAD_EN) begin
      mem_q[LOAD_ADDR] <= LOAD_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            addr_q  <= ADDRESS;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            instr_q <= rd_word;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Randomised scoreboard bench for instruction_memory.
// Second instance covers the 64-bit, 1-cycle build at the top of a 4 KiB space.
module tb_instruction_memory;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd;
  logic [9:0]  addr;
  logic [31:0] instr;
  logic        busy;
  logic        err;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [7:0]  ld_data;

  logic        b_rd;
  logic [11:0] b_addr;
  logic [63:0] b_instr;
  logic        b_busy;
  logic        b_err;
  logic        b_ld_en;
  logic [11:0] b_ld_addr;
  logic [7:0]  b_ld_data;

  int vec  = 0;
  int miss = 0;

  logic [7:0]  mdl [1024];
  logic [31:0] exp_q [$];
  logic [31:0] last = '0;
  bit          busy_prev = 1'b0;

  always #5 clk = ~clk;

  instruction_memory #(
    .ADDR_W(10), .INSTR_W(32), .LATENCY(LAT)
  ) u_dut (
    .CLK(clk), .RESET(rst_n), .READ(rd), .ADDRESS(addr),
    .INSTRUCTION(instr), .BUSYWAIT(busy), .ERROR(err),
    .LOAD_EN(ld_en), .LOAD_ADDR(ld_addr), .LOAD_DATA(ld_data)
  );

  instruction_memory #(
    .ADDR_W(12), .INSTR_W(64), .LATENCY(1)
  ) u_dut64 (
    .CLK(clk), .RESET(rst_n), .READ(b_rd), .ADDRESS(b_addr),
    .INSTRUCTION(b_instr), .BUSYWAIT(b_busy), .ERROR(b_err),
    .LOAD_EN(b_ld_en), .LOAD_ADDR(b_ld_addr), .LOAD_DATA(b_ld_data)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [9:0] a);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = mdl[10'(a + 10'(b))];
    return w;
  endfunction

  // Monitor: a fetch completes when BUSYWAIT falls outside reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
    end else begin
      if (busy_prev && !busy) begin
        if (exp_q.size() == 0) begin
          vec++;
          miss++;
          $display("FAIL unexpected_fetch got=%h", instr);
        end else begin
          chk("fetch_data", instr, exp_q.pop_front());
        end
      end
      busy_prev = busy;
    end
  end

  task automatic load(input logic [9:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    mdl[a] = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic fetch(input logic [9:0] a, input bit inj, input bit cl,
                       input logic [1:0] off, input logic [7:0] d);
    logic [31:0] w;
    rd = 1'b1; addr = a;
    if (cl) begin
      ld_en = 1'b1; ld_addr = a + 10'(off); ld_data = d;
      mdl[a + 10'(off)] = d;
    end
    w = word(a);
    exp_q.push_back(w);
    #1 chk("busy_req", busy, 1);
    @(posedge clk); #1;
    ld_en = 1'b0;
    rd = 1'($urandom_range(0, 1));
    addr = 10'($urandom);
    if (inj) begin
      ld_en = 1'b1; ld_addr = '0; ld_data = ~mdl[0];
    end
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      chk("busy_wait", busy, 1);
      if (inj && i == 1) chk("err_load_wait", err, 1);
      if (inj && i == 0) begin
        @(posedge clk); #1;
        ld_en = 1'b0;
      end
    end
    @(negedge clk);
    chk("busy_done", busy, 0);
    chk("err_done", err, 0);
    rd = 1'b1;
    addr = 10'($urandom) & 10'h3fc;
    #1 chk("done_busy_low", busy, 0);
    @(posedge clk); #1;
    rd = 1'b0;
    #1 chk("done_read_ignored", busy, 0);
    last = w;
  endtask

  task automatic misaligned(input logic [9:0] a);
    rd = 1'b1; addr = a;
    #1 chk("mis_busy", busy, 0);
    @(posedge clk); #1;
    rd = 1'b0;
    chk("mis_err_pulse", err, 1);
    chk("mis_instr_hold", instr, last);
    @(posedge clk); #1;
    chk("mis_err_clear", err, 0);
    chk("mis_no_txn", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  bb [8];
    logic [63:0] bw;
    rst_n = 1'b0; rd = 1'b0; addr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    b_rd = 1'b0; b_addr = '0;
    b_ld_en = 1'b0; b_ld_addr = '0; b_ld_data = '0;
    for (int i = 0; i < 1024; i++) mdl[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_instr", instr, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_instr64", b_instr, 0);
    rd = 1'b1;
    #1 chk("rst_busy_comb", busy, 1);
    rd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) load(10'(i), 8'h00);

    load(10'd0, 8'h05); load(10'd1, 8'h00);
    load(10'd2, 8'h04); load(10'd3, 8'h00);
    fetch(10'd0, 0, 0, 2'd0, 8'h00);
    chk("word0_value", instr, 32'h0004_0005);

    misaligned(10'd2);

    load(10'd4, 8'h11); load(10'd5, 8'h22);
    load(10'd6, 8'h33); load(10'd7, 8'h44);
    fetch(10'd0, 0, 0, 2'd0, 8'h00);
    chk("addr_change_ignored", instr, 32'h0004_0005);

    fetch(10'd0, 1, 0, 2'd0, 8'h00);
    fetch(10'd0, 0, 0, 2'd0, 8'h00);
    chk("load_in_wait_dropped", instr, 32'h0004_0005);

    rd = 1'b1; addr = 10'd8;
    @(posedge clk); #1;
    rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_instr", instr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last = '0;
    fetch(10'd4, 0, 0, 2'd0, 8'h00);
    chk("post_reset_word4", instr, 32'h4433_2211);

    for (int i = 0; i < 64; i++) load(10'($urandom), 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [9:0] a;
      r = $urandom_range(0, 9);
      a = 10'($urandom) & 10'h3fc;
      if (r < 2) misaligned(a | 10'($urandom_range(1, 3)));
      else if (r < 4) fetch(a, 0, 1, 2'($urandom), 8'($urandom));
      else fetch(a, 0, 0, 2'd0, 8'h00);
    end
    chk("sb_empty", 64'(exp_q.size()), 0);

    for (int j = 0; j < 8; j++) begin
      bb[j] = 8'($urandom);
      b_ld_en = 1'b1;
      b_ld_addr = 12'hff8 + 12'(j);
      b_ld_data = bb[j];
      @(posedge clk); #1;
    end
    b_ld_en = 1'b0;
    bw = '0;
    for (int j = 0; j < 8; j++) bw[8*j +: 8] = bb[j];
    b_rd = 1'b1; b_addr = 12'hff8;
    #1 chk("w64_busy_req", b_busy, 1);
    @(posedge clk); #1;
    b_rd = 1'b0;
    b_addr = 12'h000;
    @(negedge clk);
    chk("w64_busy_wait", b_busy, 1);
    @(negedge clk);
    chk("w64_busy_done", b_busy, 0);
    chk("w64_word", b_instr, bw);
    chk("w64_err", b_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
